mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one parameterized mux (2**SEL typed entries: op-code enums or memory-control structs) among 2**SEL requesters.
- Drives the mux select index and a valid/ready handshake toward the single downstream consumer.
- Holds the select stable for the whole grant, with bounded bursts.
- Sits between the requester-side Entry array and the consumer of the mux output Sal.

Parameters:
- SEL, 2, select width; requester count N = 2**SEL.
- MAX_BURST, 4, maximum transfers per grant (>=1); a counter of width $clog2(MAX_BURST+1) tracks it.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Req  input  N  per-requester request; bit i means Entry[i] holds a valid item.
- Last  input  N  per-requester end-of-burst marker, qualified by a transfer.
- Ready  input  1  downstream accepts the current mux output.
- Select  output  SEL  index driving the mux Select port.
- Grant  output  N  one-hot current grant; all zero when idle.
- Valid  output  1  mux output Sal is valid for downstream.

Behaviour:
- One clock (Clk); reset is asynchronous, active-low (Rst_n). Assertion clears all state immediately; release is synchronous.
- Reset values:
  - Select=0, Grant=0, Valid=0.
  - Priority pointer Ptr=0, burst count Cnt=0, state IDLE.
- States: IDLE, GRANT.
- IDLE:
  - Valid=0, Grant=0; Select holds its last value.
  - If Req==0: stay in IDLE.
  - Otherwise, at the edge: choose the first set Req bit searching Ptr, Ptr+1, ..., wrapping mod N.
  - Load Select=index and Grant=onehot(index); go to GRANT.
  - Req-to-Grant latency: 1 cycle.
- GRANT:
  - Valid = Req[Select] (combinational from registered Select).
  - Transfer = Valid & Ready. On each transfer, Cnt increments.
  - Select and Grant must not change while Valid & !Ready.
- Release conditions, evaluated at the edge:
  - (a) Transfer & Last[Select].
  - (b) Transfer & Cnt==MAX_BURST-1.
  - (c) Req[Select]==0, i.e. the requester withdrew. No transfer is counted.
- On release:
  - Ptr = (Select+1) mod N (N-1 wraps to 0); Cnt=0.
  - Re-arbitrate in the same edge using the new Ptr over the current Req, including the releasing requester at lowest priority.
  - If any Req is set: load the new Select/Grant and remain in GRANT. There are no idle cycles between back-to-back grants.
  - If no Req is set: go to IDLE and clear Grant.
- Without a release condition, GRANT persists and Select stays fixed.
- Ready is ignored in IDLE.
- MAX_BURST=1: every transfer releases.
- Reset mid-burst: Valid drops asynchronously. Any item pending on the mux is not transferred and must be re-presented by its requester.
- Pure control block; Entry data never passes through it.

Test Plan:
- Reset with Req=4'b1111 held → Select=0, Grant=0, Valid=0 while Rst_n=0. First edge after release: Grant=4'b0001, Valid=1.
- Req=4'b1111 constant, Ready=1, Last=4'b1111 → grants rotate 0,1,2,3,0 on consecutive cycles. One transfer per cycle, no gaps.
- Req=4'b0001, Ready=1, Last=0, MAX_BURST=4 → 4 transfers with Select=0. Release, then immediate re-grant to 0 (only requester); Cnt restarts.
- Grant on requester 2, Ready=0 for 5 cycles → Select=2 and Valid=1 stable throughout. Ready=1 with Last[2]=1 → next grant goes to 3 if Req[3]=1, else the next set bit after 3 with wrap.
- Grant on requester 3 while Req=4'b1001 → on release, Ptr wraps to 0 and Grant=4'b0001.
- Granted requester 1 drops Req[1] with Ready=0 → Valid=0 that cycle, no transfer counted. Next edge: grant passes to the next requester, or to IDLE with Grant=0 if Req=0.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bundle of the round-robin mux arbiter, plus read-only debug taps.
// Handshake: Valid is held while Ready is low, with Select/Grant frozen, and a transfer happens on a
// rising Clk edge where Valid && Ready. Valid may fall without a transfer if the granted requester drops Req.
interface mux_rr_arbiter_if #(
  parameter int SEL       = 2,
  parameter int MAX_BURST = 4
);
  localparam int N  = 1 << SEL;
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [N-1:0]   Req;
  logic [N-1:0]   Last;
  logic           Ready;
  logic [SEL-1:0] Select;
  logic [N-1:0]   Grant;
  logic           Valid;

  // Debug view of internal state: 0 = IDLE, 1 = GRANT.
  logic           dbg_state;
  logic [SEL-1:0] dbg_ptr;
  logic [CW-1:0]  dbg_cnt;

  modport master (
    output Req, Last, Ready,
    input  Select, Grant, Valid, dbg_state, dbg_ptr, dbg_cnt
  );

  modport slave (
    input  Req, Last, Ready,
    output Select, Grant, Valid, dbg_state, dbg_ptr, dbg_cnt
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 2**SEL-entry mux.
// A grant is held until Last, a MAX_BURST-transfer burst, or requester withdrawal, then re-arbitrated.
module mux_rr_arbiter #(
  parameter int SEL       = 2,
  parameter int MAX_BURST = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  mux_rr_arbiter_if.slave  bus
);
  localparam int N  = 1 << SEL;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [SEL-1:0] sel_q, sel_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [SEL-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           valid;
  logic           xfer;
  logic           burst_end;
  logic           release_now;
  logic [SEL-1:0] arb_ptr;
  logic [SEL-1:0] idx;
  logic [SEL-1:0] pick_idx;
  logic           pick_found;

  assign valid       = (state_q == GRANT) && bus.Req[sel_q];
  assign xfer        = valid && bus.Ready;
  assign burst_end   = (cnt_q == CW'(MAX_BURST - 1));
  assign release_now = (state_q == GRANT) &&
                       (!bus.Req[sel_q] || (xfer && (bus.Last[sel_q] || burst_end)));

  // On release the search starts just past the outgoing owner, so it ends up lowest priority.
  assign arb_ptr = (state_q == GRANT) ? sel_q + SEL'(1) : ptr_q;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = '0;
    for (int i = 0; i < N; i++) begin
      idx = arb_ptr + SEL'(i);
      if (!pick_found && bus.Req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          grant_d = N'(1) << pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d = sel_q + SEL'(1);
          cnt_d = '0;
          if (pick_found) begin
            sel_d   = pick_idx;
            grant_d = N'(1) << pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Select    = sel_q;
  assign bus.Grant     = grant_q;
  assign bus.Valid     = valid;
  assign bus.dbg_state = state_q;
  assign bus.dbg_ptr   = ptr_q;
  assign bus.dbg_cnt   = cnt_q;
endmodule
